// File: rtl/bus_scheduler_pkg.sv
// Shared timing constants and state type for the RAM/bus time-slicer.
package bus_scheduler_pkg;

   localparam int SYS_CLOCK_MHZ = 64;
   localparam int CPU_MHZ       = 1;
   localparam int CYCLE_COUNT   = SYS_CLOCK_MHZ / CPU_MHZ;

   // Round up so a window is never shorter than the requested time.
   function automatic int ns_to_cycles(input int ns);
      return (ns * SYS_CLOCK_MHZ + 999) / 1000;
   endfunction

   localparam int ACCESS_CYCLES = ns_to_cycles(70);

   typedef enum logic [1:0] {
      IDLE,
      WB_ACCESS,
      CPU_ACCESS
   } bus_state_t;

endpackage

// File: rtl/bus_scheduler_phase_counter.sv
// Free-running frame phase counter; exposes next-phase decodes so the
// scheduler can register its outputs in step with the phase.
module bus_phase_counter #(
   parameter int CYCLE_COUNT = 64
) (
   input  logic                           clock_i,
   input  logic                           reset_n_i,
   output logic [$clog2(CYCLE_COUNT)-1:0] phase_o,
   output logic [$clog2(CYCLE_COUNT)-1:0] phase_next_o,
   output logic                           frame_start_o,
   output logic                           phi2_half_o
);

   localparam int PHASE_W = $clog2(CYCLE_COUNT);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLE_COUNT - 1);
   localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(CYCLE_COUNT / 2);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;

   always_comb begin
      if (phase_q == PHASE_LAST) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PHASE_W'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_o       = phase_q;
   assign phase_next_o  = phase_d;
   assign frame_start_o = (phase_q == PHASE_LAST);
   assign phi2_half_o   = (phase_d >= PHASE_HALF);

endmodule

// File: rtl/bus_scheduler.sv
// Time-slices the shared RAM/bus between the Wishbone port and the 6502 CPU,
// one fixed window per requester per CPU cycle, and generates phi2.
module bus_scheduler
   import bus_scheduler_pkg::*;
#(
   parameter int CYCLE_COUNT    = bus_scheduler_pkg::CYCLE_COUNT,
   parameter int WB_SLOT_PHASE  = 0,
   parameter int CPU_SLOT_PHASE = 40,
   parameter int ACCESS_CYCLES  = bus_scheduler_pkg::ACCESS_CYCLES
) (
   input  logic                           clock_i,
   input  logic                           reset_n_i,
   input  logic                           cpu_ready_i,
   input  logic                           cpu_reset_i,
   input  logic                           wb_cyc_i,
   input  logic                           wb_stb_i,
   output logic                           wb_stall_o,
   output logic                           wb_ack_o,
   output logic                           wb_grant_o,
   output logic                           cpu_grant_o,
   output logic                           ram_strobe_o,
   output logic                           cpu_phi2_o,
   output logic                           cpu_reset_n_o,
   output logic [$clog2(CYCLE_COUNT)-1:0] phase_o
);

   localparam int PHASE_W = $clog2(CYCLE_COUNT);
   localparam int CNT_W   = $clog2(ACCESS_CYCLES + 1);
   localparam logic [PHASE_W-1:0] WB_PH    = PHASE_W'(WB_SLOT_PHASE);
   localparam logic [PHASE_W-1:0] CPU_PH   = PHASE_W'(CPU_SLOT_PHASE);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   generate
      if ((ACCESS_CYCLES < 1) ||
          (WB_SLOT_PHASE + ACCESS_CYCLES > CYCLE_COUNT) ||
          (CPU_SLOT_PHASE + ACCESS_CYCLES > CYCLE_COUNT) ||
          (CPU_SLOT_PHASE < CYCLE_COUNT / 2) ||
          !((WB_SLOT_PHASE + ACCESS_CYCLES <= CPU_SLOT_PHASE) ||
            (CPU_SLOT_PHASE + ACCESS_CYCLES <= WB_SLOT_PHASE))) begin : g_bad_slots
         $error("bus_scheduler: access windows overlap or do not fit the frame");
      end
   endgenerate

   logic [PHASE_W-1:0] phase_s;
   logic [PHASE_W-1:0] phase_next_s;
   logic               frame_start_s;
   logic               phi2_half_s;

   bus_phase_counter #(
      .CYCLE_COUNT(CYCLE_COUNT)
   ) u_phase (
      .clock_i      (clock_i),
      .reset_n_i    (reset_n_i),
      .phase_o      (phase_s),
      .phase_next_o (phase_next_s),
      .frame_start_o(frame_start_s),
      .phi2_half_o  (phi2_half_s)
   );

   bus_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic run_q, run_d;
   logic pending_q, pending_d;
   logic abort_q, abort_d;
   logic ack_q, ack_d;
   logic stall_q, strobe_q, phi2_q, cpu_reset_n_q;
   logic wb_grant_q, cpu_grant_q;
   logic accept_s, wb_start_s, cpu_start_s, window_end_s;

   // A pending request may still join the window at the very edge it was
   // accepted on, which is what lets a phase-63 strobe catch phase 0.
   always_comb begin
      accept_s     = wb_cyc_i && wb_stb_i && !stall_q;
      run_d        = frame_start_s ? cpu_ready_i : run_q;
      wb_start_s   = (state_q == IDLE) && (phase_next_s == WB_PH) &&
                     (accept_s || (pending_q && wb_cyc_i));
      cpu_start_s  = (state_q == IDLE) && (phase_next_s == CPU_PH) && run_d;
      window_end_s = (state_q != IDLE) && (cnt_q == '0);
      abort_d      = abort_q || ((state_q == WB_ACCESS) && !wb_cyc_i);
      ack_d        = 1'b0;
      if (accept_s) begin
         pending_d = 1'b1;
      end else if ((state_q == WB_ACCESS) && window_end_s) begin
         pending_d = 1'b0;
         ack_d     = !abort_d;
      end else if ((state_q != WB_ACCESS) && !wb_cyc_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         run_q         <= 1'b0;
         cpu_reset_n_q <= 1'b0;
         phi2_q        <= 1'b0;
         pending_q     <= 1'b0;
         abort_q       <= 1'b0;
         ack_q         <= 1'b0;
         stall_q       <= 1'b0;
         strobe_q      <= 1'b0;
         wb_grant_q    <= 1'b0;
         cpu_grant_q   <= 1'b0;
      end else begin
         run_q <= run_d;
         if (frame_start_s) begin
            cpu_reset_n_q <= !cpu_reset_i;
         end else begin
            cpu_reset_n_q <= cpu_reset_n_q;
         end
         phi2_q    <= run_d && phi2_half_s;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         stall_q   <= pending_d || ack_d;
         strobe_q  <= wb_start_s || cpu_start_s;
         case (state_q)
            IDLE: begin
               abort_q <= 1'b0;
               if (wb_start_s) begin
                  state_q    <= WB_ACCESS;
                  cnt_q      <= CNT_LOAD;
                  wb_grant_q <= 1'b1;
               end else if (cpu_start_s) begin
                  state_q     <= CPU_ACCESS;
                  cnt_q       <= CNT_LOAD;
                  cpu_grant_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            WB_ACCESS, CPU_ACCESS: begin
               if (window_end_s) begin
                  state_q     <= IDLE;
                  abort_q     <= 1'b0;
                  wb_grant_q  <= 1'b0;
                  cpu_grant_q <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q - CNT_W'(1);
                  abort_q <= abort_d;
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               abort_q     <= 1'b0;
               wb_grant_q  <= 1'b0;
               cpu_grant_q <= 1'b0;
            end
         endcase
      end
   end

   assign phase_o       = phase_s;
   assign wb_stall_o    = stall_q;
   assign wb_ack_o      = ack_q;
   assign wb_grant_o    = wb_grant_q;
   assign cpu_grant_o   = cpu_grant_q;
   assign ram_strobe_o  = strobe_q;
   assign cpu_phi2_o    = phi2_q;
   assign cpu_reset_n_o = cpu_reset_n_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: directed scenarios plus random
// traffic, all checked every cycle against a cycle-time request model.
module tb_bus_scheduler;

   localparam int FRAME = 64;
   localparam int ACC   = 5;

   logic clk = 1'b0;
   logic reset_n, cpu_ready, cpu_reset, cyc, stb;
   logic wb_stall_o, wb_ack_o, wb_grant_o, cpu_grant_o, ram_strobe_o;
   logic cpu_phi2_o, cpu_reset_n_o;
   logic [5:0] phase_o;

   int checks = 0;
   int fails  = 0;

   bus_scheduler dut (
      .clock_i      (clk),
      .reset_n_i    (reset_n),
      .cpu_ready_i  (cpu_ready),
      .cpu_reset_i  (cpu_reset),
      .wb_cyc_i     (cyc),
      .wb_stb_i     (stb),
      .wb_stall_o   (wb_stall_o),
      .wb_ack_o     (wb_ack_o),
      .wb_grant_o   (wb_grant_o),
      .cpu_grant_o  (cpu_grant_o),
      .ram_strobe_o (ram_strobe_o),
      .cpu_phi2_o   (cpu_phi2_o),
      .cpu_reset_n_o(cpu_reset_n_o),
      .phase_o      (phase_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: absolute cycle index, frame phase, and one outstanding request
   // described by the cycle its window starts and whether it was aborted.
   bit m_valid = 1'b0;
   int m_t, m_phase, r_start;
   bit m_run, m_rstn, r_live, r_abort;
   bit e_stall, e_ack, e_wbg, e_cpug, e_phi2, e_strobe;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_valid = 1'b1; m_t = 0; m_phase = 0; m_run = 1'b0; m_rstn = 1'b0;
         r_live = 1'b0; r_abort = 1'b0; r_start = 0;
      end else if (m_valid) begin
         if (r_live && !cyc) begin
            if (m_t < r_start) r_live = 1'b0;
            else if (m_t < r_start + ACC) r_abort = 1'b1;
         end
         if (!e_stall && cyc && stb) begin
            r_live  = 1'b1;
            r_abort = 1'b0;
            r_start = m_t + FRAME - m_phase;
         end
         if (m_phase == FRAME - 1) begin
            m_run  = cpu_ready;
            m_rstn = !cpu_reset;
         end
         m_phase = (m_phase + 1) % FRAME;
         m_t++;
         if (r_live && (m_t > r_start + ACC - (r_abort ? 1 : 0))) r_live = 1'b0;
      end
      e_stall  = r_live;
      e_wbg    = r_live && (m_t >= r_start) && (m_t < r_start + ACC);
      e_ack    = r_live && !r_abort && (m_t == r_start + ACC);
      e_cpug   = m_run && (m_phase >= 40) && (m_phase < 40 + ACC);
      e_phi2   = m_run && (m_phase >= FRAME / 2);
      e_strobe = (e_wbg && (m_t == r_start)) || (m_run && (m_phase == 40));
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("phase",     phase_o,       m_phase);
         chk("stall",     wb_stall_o,    e_stall);
         chk("ack",       wb_ack_o,      e_ack);
         chk("wb_grant",  wb_grant_o,    e_wbg);
         chk("cpu_grant", cpu_grant_o,   e_cpug);
         chk("strobe",    ram_strobe_o,  e_strobe);
         chk("phi2",      cpu_phi2_o,    e_phi2);
         chk("cpu_rst_n", cpu_reset_n_o, m_rstn);
      end
   end

   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((phase_o != p) && (n < 200));
      chk("wait_phase_reached", phase_o, p);
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!wb_ack_o && (lat < 200));
      chk("ack_seen", wb_ack_o, 1);
   endtask

   task automatic request_now();
      cyc = 1'b1;
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
   endtask

   int lat;

   initial begin
      reset_n = 1'b0; cpu_ready = 1'b0; cpu_reset = 1'b1; cyc = 1'b0; stb = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_phase", phase_o, 0);
      chk("rst_phi2", cpu_phi2_o, 0);
      chk("rst_cpu_rst_n", cpu_reset_n_o, 0);
      chk("rst_grants", {wb_grant_o, cpu_grant_o, ram_strobe_o}, 0);
      chk("rst_ack_stall", {wb_ack_o, wb_stall_o}, 0);

      // CPU runs from the next frame start.
      reset_n = 1'b1; cpu_ready = 1'b1; cpu_reset = 1'b0;
      wait_phase(31);
      chk("first_frame_no_phi2_at31", cpu_phi2_o, 0);
      wait_phase(0);
      chk("frame_cpu_rst_n", cpu_reset_n_o, 1);
      chk("phi2_low_at0", cpu_phi2_o, 0);
      wait_phase(32);
      chk("phi2_high_at32", cpu_phi2_o, 1);
      wait_phase(40);
      chk("cpu_grant_at40", cpu_grant_o, 1);
      chk("strobe_at40", ram_strobe_o, 1);
      @(negedge clk);
      chk("strobe_gone_at41", ram_strobe_o, 0);
      wait_phase(45);
      chk("cpu_grant_off_at45", cpu_grant_o, 0);

      // Single strobe at phase 10, served next frame.
      wait_phase(10);
      request_now();
      chk("stall_after_accept", wb_stall_o, 1);
      wait_ack(lat);
      chk("ack_phase", phase_o, 5);
      @(negedge clk);
      chk("stall_clear_phase6", wb_stall_o, 0);

      // Strobe at phase 63 catches the immediately following window.
      wait_phase(63);
      request_now();
      chk("grant_at_phase0", wb_grant_o, 1);
      chk("grant_phase", phase_o, 0);
      wait_ack(lat);
      chk("ack_latency_from63", lat, 5);
      // Strobe at phase 0 waits a whole frame.
      wait_phase(0);
      request_now();
      chk("no_grant_after_phase0_accept", wb_grant_o, 0);
      wait_ack(lat);
      chk("ack_latency_from0", lat, 68);
      cyc = 1'b0;

      // Dropping ready mid-frame affects only the next frame.
      wait_phase(20);
      cpu_ready = 1'b0;
      wait_phase(40);
      chk("cpu_grant_kept", cpu_grant_o, 1);
      wait_phase(50);
      chk("phi2_kept", cpu_phi2_o, 1);
      wait_phase(40);
      chk("cpu_grant_stopped", cpu_grant_o, 0);
      chk("phi2_stopped", cpu_phi2_o, 0);
      cpu_ready = 1'b1;

      // Abort during the window: no ack, stall released.
      wait_phase(10);
      request_now();
      wait_phase(2);
      chk("abort_in_window", wb_grant_o, 1);
      cyc = 1'b0;
      wait_phase(5);
      chk("abort_no_ack", wb_ack_o, 0);
      chk("abort_stall_clear", wb_stall_o, 0);

      // Reset in the middle of a window.
      wait_phase(10);
      request_now();
      wait_phase(2);
      chk("grant_before_reset", wb_grant_o, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("grant_dropped_by_reset", wb_grant_o, 0);
      chk("phase_after_reset", phase_o, 0);
      reset_n = 1'b1; cyc = 1'b0;

      // Random traffic, checked against the model each cycle.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 39) == 0) cyc = !cyc;
         stb = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) cpu_ready = !cpu_ready;
         if ($urandom_range(0, 299) == 0) cpu_reset = !cpu_reset;
         reset_n = ($urandom_range(0, 999) != 0);
         @(negedge clk);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
